// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Defining MDU_MADD_EN adds the accumulate ops (madd/maddu/msub/msubu).
module mdu #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdop_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  mdop_e            op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  // Start decode for the incoming opcode
  logic start_c;
  logic start_div_c;

  always_comb begin
    start_c     = 1'b0;
    start_div_c = 1'b0;
    case (mdop_e'(mdop))
      OP_MULT, OP_MULTU: start_c = 1'b1;
      OP_DIV, OP_DIVU: begin
        start_c     = 1'b1;
        start_div_c = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: start_c = 1'b1;
`endif
      default: ;
    endcase
  end

  // One 33x33 signed multiplier serves both signed and unsigned products
  logic               mul_signed_c;
  logic signed [32:0] mul_a_c;
  logic signed [32:0] mul_b_c;
  logic signed [65:0] mul_full_c;
  logic [63:0]        prod_c;

  always_comb begin
    mul_signed_c = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    mul_a_c      = {mul_signed_c & a_q[31], a_q};
    mul_b_c      = {mul_signed_c & b_q[31], b_q};
    mul_full_c   = mul_a_c * mul_b_c;
    prod_c       = mul_full_c[63:0];
  end

  // Divide on magnitudes, then restore signs; INT_MIN / -1 wraps to INT_MIN naturally
  logic        div_signed_c;
  logic        div_zero_c;
  logic [31:0] dvd_c;
  logic [31:0] dvs_c;
  logic [31:0] dvs_safe_c;
  logic [31:0] uquo_c;
  logic [31:0] urem_c;
  logic [31:0] quo_c;
  logic [31:0] rem_c;

  always_comb begin
    div_signed_c = (op_q == OP_DIV);
    div_zero_c   = (b_q == 32'd0);
    dvd_c        = (div_signed_c && a_q[31]) ? (~a_q + 32'd1) : a_q;
    dvs_c        = (div_signed_c && b_q[31]) ? (~b_q + 32'd1) : b_q;
    dvs_safe_c   = div_zero_c ? 32'd1 : dvs_c;
    uquo_c       = dvd_c / dvs_safe_c;
    urem_c       = dvd_c % dvs_safe_c;
    quo_c        = (div_signed_c && (a_q[31] ^ b_q[31])) ? (~uquo_c + 32'd1) : uquo_c;
    rem_c        = (div_signed_c && a_q[31]) ? (~urem_c + 32'd1) : urem_c;
  end

  // Next-state, operand capture and HI/LO commit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          a_d     = A;
          b_d     = B;
          op_d    = mdop_e'(mdop);
          cnt_d   = start_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else if (mdop_e'(mdop) == OP_MTHI) begin
          hi_d = A;
        end else if (mdop_e'(mdop) == OP_MTLO) begin
          lo_d = A;
        end
      end

      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_c;
            OP_DIV, OP_DIVU: begin
              if (!div_zero_c) begin
                hi_d = rem_c;
                lo_d = quo_c;
              end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_c;
            OP_MSUB, OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_c;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu; a per-cycle reference model predicts busy/HI/LO.
module tb_mdu;

  localparam int unsigned MUL_N = 5;
  localparam int unsigned DIV_N = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .mdop (mdop),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int          due;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc_n);
    end
  endtask

  // Reference model: architectural state plus remaining busy cycles and pending result
  int          m_left = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_res  = '0;
  bit          m_ok   = 1'b0;

  function automatic bit is_start(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd4) || (MADD_EN && op >= 4'd7 && op <= 4'd10);
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc,
                                             output bit ok);
    longint      sa = longint'(int'(a));
    longint      sb = longint'(int'(b));
    logic [63:0] ps = 64'(sa * sb);
    logic [63:0] pu = 64'(a) * 64'(b);
    int          qa = int'(a);
    int          qb = int'(b);
    ok = 1'b1;
    case (op)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: begin
        if (b == 32'd0) begin
          ok = 1'b0;
          return acc;
        end
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(qa % qb), 32'(qa / qb)};
      end
      4'd4: begin
        if (b == 32'd0) begin
          ok = 1'b0;
          return acc;
        end
        return {a % b, a / b};
      end
      4'd7:    return acc + ps;
      4'd8:    return acc + pu;
      4'd9:    return acc - ps;
      4'd10:   return acc - pu;
      default: return acc;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
    if (r) begin
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_ok) {m_hi, m_lo} = m_res;
    end else if (is_start(op)) begin
      m_left = (op == 4'd3 || op == 4'd4) ? int'(DIV_N) : int'(MUL_N);
      m_res  = ref_result(op, a, b, {m_hi, m_lo}, m_ok);
    end else if (op == 4'd5) begin
      m_hi = a;
    end else if (op == 4'd6) begin
      m_lo = a;
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after the next edge
  task automatic cyc(input logic r, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b);
    exp_t e;
    reset = r;
    mdop  = op;
    A     = a;
    B     = b;
    model_step(r, op, a, b);
    e.due  = cyc_n + 1;
    e.busy = (m_left > 0);
    e.hi   = m_hi;
    e.lo   = m_lo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nb);
    cyc(1'b0, op, a, b);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      nb++;
      cyc(1'b0, 4'd0, 32'd0, 32'd0);
    end
  endtask

  // Monitor: compare every due expectation against the DUT on the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc_n) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_busy", 32'(busy), 32'(e.busy));
      chk("sb_hi", HI, e.hi);
      chk("sb_lo", LO, e.lo);
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    cyc(1'b1, 4'd0, 32'd0, 32'd0);
    cyc(1'b1, 4'd0, 32'd0, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, nb);
    chk("mult_busy_len", 32'(nb), 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, nb);
    chk("multu_busy_len", 32'(nb), 32'd5);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, nb);
    chk("div_busy_len", 32'(nb), 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    run_op(4'd4, 32'd7, 32'd0, nb);
    chk("divu0_busy_len", 32'(nb), 32'd10);
    chk("divu0_hi", HI, 32'hFFFF_FFFF);
    chk("divu0_lo", LO, 32'hFFFF_FFFD);

    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'd0);

    cyc(1'b0, 4'd5, 32'h1234_5678, 32'd0);
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_busy", 32'(busy), 32'd0);
    cyc(1'b0, 4'd6, 32'h9ABC_DEF0, 32'd0);
    chk("mtlo_lo", LO, 32'h9ABC_DEF0);
    chk("mtlo_busy", 32'(busy), 32'd0);

    // mthi during RUN must be ignored
    cyc(1'b0, 4'd1, 32'd3, 32'd4);
    cyc(1'b0, 4'd5, 32'hDEAD_BEEF, 32'd0);
    chk("midrun_hi_held", HI, 32'h1234_5678);
    for (int i = 0; i < 20 && busy === 1'b1; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0);
    chk("midrun_hi", HI, 32'd0);
    chk("midrun_lo", LO, 32'd12);

    // reset during the third busy cycle aborts the op
    cyc(1'b0, 4'd1, 32'd5, 32'd7);
    cyc(1'b0, 4'd0, 32'd0, 32'd0);
    cyc(1'b0, 4'd0, 32'd0, 32'd0);
    cyc(1'b1, 4'd0, 32'd0, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    run_op(4'd2, 32'd2, 32'd3, nb);
    chk("after_abort_len", 32'(nb), 32'd5);
    chk("after_abort_lo", LO, 32'd6);

    // back-to-back: divu issued on the cycle busy falls
    run_op(4'd2, 32'h0001_0000, 32'h0001_0000, nb);
    chk("b2b_hi", HI, 32'd1);
    chk("b2b_lo", LO, 32'd0);
    run_op(4'd4, 32'd100, 32'd7, nb);
    chk("b2b_div_len", 32'(nb), 32'd10);
    chk("b2b_div_lo", LO, 32'd14);
    chk("b2b_div_hi", HI, 32'd2);

    // accumulate ops (or no-ops when the feature is absent)
    cyc(1'b0, 4'd5, 32'd0, 32'd0);
    cyc(1'b0, 4'd6, 32'hFFFF_FFFF, 32'd0);
    run_op(4'd8, 32'd1, 32'd1, nb);
    chk("maddu_len", 32'(nb), MADD_EN ? 32'd5 : 32'd0);
    chk("maddu_hi", HI, MADD_EN ? 32'd1 : 32'd0);
    chk("maddu_lo", LO, MADD_EN ? 32'd0 : 32'hFFFF_FFFF);
    cyc(1'b0, 4'd5, 32'd0, 32'd0);
    cyc(1'b0, 4'd6, 32'd0, 32'd0);
    run_op(4'd9, 32'd1, 32'd2, nb);
    chk("msub_len", 32'(nb), MADD_EN ? 32'd5 : 32'd0);
    chk("msub_hi", HI, MADD_EN ? 32'hFFFF_FFFF : 32'd0);
    chk("msub_lo", LO, MADD_EN ? 32'hFFFF_FFFE : 32'd0);

    // random traffic, including ops during RUN and occasional reset
    for (int i = 0; i < 2500; i++) begin
      logic       r;
      logic [3:0] op;
      r  = ($urandom_range(0, 199) == 0);
      op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      cyc(r, op, rand_operand(), rand_operand());
    end

    for (int i = 0; i < 12; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
